// File: rtl/floppy_stepper.sv
// Drives one floppy drive's STEP/DIR lines so the head-step rate sounds a note.
// After reset it homes the head to track 0, then bounces between the track limits while playing.
module floppy_stepper #(
    parameter int          TRACKS    = 80,
    parameter int          HOME_HALF = 100000,
    parameter logic [21:0] SILENT    = 22'h3fffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] setpoint,
    input  logic        gate,
    output logic        step_n,
    output logic        dir,
    output logic [6:0]  track,
    output logic        homing
);

    typedef enum logic [1:0] {
        S_HOME,
        S_IDLE,
        S_PLAY
    } state_t;

    localparam logic [21:0] HOME_LIMIT = 22'(HOME_HALF);
    localparam logic [6:0]  TRACK_MAX  = 7'(TRACKS - 1);

    state_t      r_state, w_state_nx;
    logic [21:0] r_count, w_count_nx;
    logic        r_step_n, w_step_n_nx;
    logic        r_dir, w_dir_nx;
    logic        r_homing, w_homing_nx;
    logic [6:0]  r_track, w_track_nx;

    logic [21:0] w_limit;
    logic        w_due;
    logic        w_note_ok;
    logic        w_engine;

    // Widened compare so a limit of 0 or 1 toggles immediately instead of wrapping.
    assign w_limit   = (r_state == S_HOME) ? HOME_LIMIT : setpoint;
    assign w_due     = ({1'b0, r_count} + 23'd1) >= {1'b0, w_limit};
    assign w_note_ok = gate && (setpoint != SILENT) && (setpoint >= 22'd2);

    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_step_n_nx = r_step_n;
        w_dir_nx    = r_dir;
        w_homing_nx = r_homing;
        w_track_nx  = r_track;
        w_engine    = 1'b0;

        case (r_state)
            S_HOME: w_engine = 1'b1;
            S_IDLE: begin
                w_count_nx  = '0;
                w_step_n_nx = 1'b1;
                if (w_note_ok) w_state_nx = S_PLAY;
            end
            S_PLAY: begin
                // A due toggle while high still falls, so a low half is never skipped or cut short.
                if (!w_note_ok && r_step_n && !w_due) begin
                    w_state_nx = S_IDLE;
                    w_count_nx = '0;
                end else begin
                    w_engine = 1'b1;
                end
            end
            default: w_state_nx = S_HOME;
        endcase

        if (w_engine) begin
            if (w_due) begin
                w_count_nx  = '0;
                w_step_n_nx = ~r_step_n;
                if (r_step_n) begin
                    w_track_nx = r_dir ? (r_track - 7'd1) : (r_track + 7'd1);
                end else begin
                    // Reversing on the rising edge gives DIR a full half-period of setup.
                    if (r_track == '0)            w_dir_nx = 1'b0;
                    else if (r_track == TRACK_MAX) w_dir_nx = 1'b1;
                    if (r_state == S_HOME && r_track == '0) begin
                        w_homing_nx = 1'b0;
                        w_state_nx  = S_IDLE;
                    end
                    if (r_state == S_PLAY && !w_note_ok) w_state_nx = S_IDLE;
                end
            end else begin
                w_count_nx = r_count + 22'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_HOME;
            r_count  <= '0;
            r_step_n <= 1'b1;
            r_dir    <= 1'b1;
            r_homing <= 1'b1;
            r_track  <= TRACK_MAX;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_step_n <= w_step_n_nx;
            r_dir    <= w_dir_nx;
            r_homing <= w_homing_nx;
            r_track  <= w_track_nx;
        end
    end

    assign step_n = r_step_n;
    assign dir    = r_dir;
    assign track  = r_track;
    assign homing = r_homing;

endmodule

// File: tb/tb_floppy_stepper.sv
// Self-checking bench for floppy_stepper: directed scenarios plus random gate/setpoint traffic,
// compared every clock against an integer reference model of the stepping rules.
module tb_floppy_stepper;

    localparam int          TRACKS    = 80;
    localparam int          HOME_HALF = 4;
    localparam logic [21:0] SIL       = 22'h3fffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] setpoint = '0;
    logic        gate = 1'b0;
    logic        step_n;
    logic        dir;
    logic [6:0]  track;
    logic        homing;

    floppy_stepper #(
        .TRACKS   (TRACKS),
        .HOME_HALF(HOME_HALF),
        .SILENT   (SIL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .setpoint(setpoint),
        .gate    (gate),
        .step_n  (step_n),
        .dir     (dir),
        .track   (track),
        .homing  (homing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = homing, 1 = idle, 2 = playing; elapsed = clocks in current half.
    int m_mode, m_elapsed, m_pos;
    bit m_high, m_toward0, m_homing;

    task automatic model_step();
        int  half;
        bit  ok, due;
        if (rst) begin
            m_mode = 0; m_elapsed = 0; m_pos = TRACKS - 1;
            m_high = 1; m_toward0 = 1; m_homing = 1;
            return;
        end
        ok   = gate && (setpoint != SIL) && (int'(setpoint) >= 2);
        half = (m_mode == 0) ? HOME_HALF : int'(setpoint);
        due  = (m_elapsed + 1 >= half);
        if (m_mode == 1) begin
            m_elapsed = 0; m_high = 1;
            if (ok) m_mode = 2;
            return;
        end
        if (m_mode == 2 && !ok && m_high && !due) begin
            m_mode = 1; m_elapsed = 0;
            return;
        end
        if (!due) begin
            m_elapsed++;
            return;
        end
        m_elapsed = 0;
        if (m_high) begin
            m_high = 0;
            m_pos  = m_toward0 ? m_pos - 1 : m_pos + 1;
        end else begin
            m_high = 1;
            if (m_pos == 0)          m_toward0 = 0;
            if (m_pos == TRACKS - 1) m_toward0 = 1;
            if (m_mode == 0 && m_pos == 0) begin
                m_homing = 0; m_mode = 1;
            end else if (m_mode == 2 && !ok) begin
                m_mode = 1;
            end
        end
    endtask

    int  cyc = 0;
    int  falls = 0;
    int  last_fall = -1;
    bit  prev_step_n = 1'b1;

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("step_n", int'(step_n), int'(m_high));
        check("dir", int'(dir), int'(m_toward0));
        check("track", int'(track), m_pos);
        check("homing", int'(homing), int'(m_homing));
        check("track_range", int'(int'(track) < TRACKS), 1);
        if (rst) begin
            falls = 0;
            last_fall = -1;
        end else if (prev_step_n && !step_n) begin
            falls++;
            if (homing && last_fall >= 0) check("home_gap", cyc - last_fall, 2 * HOME_HALF);
            last_fall = cyc;
        end
        prev_step_n = step_n;
    endtask

    task automatic run_homing(input string tag);
        for (int i = 0; i < 2000 && homing; i++) tick();
        check({tag, "_done"}, int'(homing), 0);
        check({tag, "_falls"}, falls, TRACKS - 1);
        check({tag, "_track"}, int'(track), 0);
        check({tag, "_dir"}, int'(dir), 0);
        check({tag, "_step_n"}, int'(step_n), 1);
    endtask

    task automatic wait_low(input string tag);
        for (int i = 0; i < 300 && step_n; i++) tick();
        check(tag, int'(step_n), 0);
    endtask

    int f0;

    initial begin
        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst_step_n", int'(step_n), 1);
        check("rst_track", int'(track), TRACKS - 1);
        check("rst_homing", int'(homing), 1);
        check("rst_dir", int'(dir), 1);

        // Homing sequence
        rst = 1'b0;
        run_homing("home1");

        // Steady tone
        gate = 1'b1;
        setpoint = 22'd10;
        f0 = falls;
        for (int i = 0; i < 100; i++) tick();
        check("tone_falls", falls - f0, 5);

        // Release two clocks into a low half
        wait_low("rel_low_seen");
        tick();
        gate = 1'b0;
        f0 = falls;
        for (int i = 0; i < 40; i++) tick();
        check("rel_nofall", falls - f0, 0);
        check("rel_high", int'(step_n), 1);

        // Silence setpoints
        gate = 1'b1;
        setpoint = SIL;
        f0 = falls;
        for (int i = 0; i < 30; i++) tick();
        setpoint = 22'd1;
        for (int i = 0; i < 30; i++) tick();
        setpoint = 22'd0;
        for (int i = 0; i < 30; i++) tick();
        check("silent_nofall", falls - f0, 0);

        // Fast tone long enough to bounce off both track limits
        setpoint = 22'd2;
        for (int i = 0; i < 700; i++) tick();

        // Random gate and setpoint traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0)
                setpoint = ($urandom_range(9) == 0) ? SIL : 22'($urandom_range(12));
            if ($urandom_range(24) == 0) gate = ~gate;
            tick();
        end

        // Reset while step_n is low
        gate = 1'b1;
        setpoint = 22'd5;
        wait_low("rstplay_low_seen");
        rst = 1'b1;
        tick();
        check("rstplay_step_n", int'(step_n), 1);
        check("rstplay_track", int'(track), TRACKS - 1);
        check("rstplay_homing", int'(homing), 1);
        check("rstplay_dir", int'(dir), 1);
        rst = 1'b0;
        gate = 1'b0;
        run_homing("home2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
